// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for LEGv8 MUL / SMULH / UMULH.
// One partial product per clock; start/busy/done handshake for pipeline stall.
module mul_unit #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] OP_SMULH = 2'b01;
   localparam logic [1:0] OP_UMULH = 2'b10;

   state_t             state_q, state_d;
   logic [1:0]         op_q;
   logic               neg_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] prod_q;      // {accumulator, multiplier} pair
   logic [CW-1:0]      cnt_q;

   logic               accept;
   logic               is_signed;
   logic [WIDTH-1:0]   a_in, b_in;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic               last_iter;

   assign accept    = start && (state_q == IDLE || state_q == DONE);
   assign is_signed = (op == OP_SMULH);
   assign a_in      = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_in      = (is_signed && b[WIDTH-1]) ? -b : b;

   // Keep the carry out of the add so the shift moves it into the MSB.
   assign sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
   assign prod_step = prod_q[0] ? {sum, prod_q[WIDTH-1:1]}
                                : {1'b0, prod_q[2*WIDTH-1:1]};
   assign prod_fix  = neg_q ? -prod_q : prod_q;
   assign last_iter = (cnt_q == CW'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: next_state gets a default before the case, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: state_d = start ? RUN : IDLE;
         RUN:        state_d = last_iter ? FIX : RUN;
         FIX:        state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN) || (state_q == FIX);
   assign done = (state_q == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         neg_q   <= 1'b0;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         result  <= '0;
      end else begin
         if (accept) begin
            op_q    <= op;
            neg_q   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand_q <= a_in;
            prod_q  <= {{WIDTH{1'b0}}, b_in};
            cnt_q   <= '0;
         end else if (state_q == RUN) begin
            prod_q <= prod_step;
            cnt_q  <= cnt_q + 1'b1;
         end else if (state_q == FIX) begin
            if (op_q == OP_SMULH || op_q == OP_UMULH)
               result <= prod_fix[2*WIDTH-1:WIDTH];
            else
               result <= prod_fix[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed handshake/reset cases plus a
// randomized regression against a 128-bit arithmetic reference model.
module tb_mul_unit;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int n_vec = 0;
   int n_err = 0;
   int done_total = 0;

   mul_unit #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rst_n && done) done_total++;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_mul(input logic [1:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
      logic [2*W-1:0] p;
      case (o)
         2'b01: begin
            p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
            return p[2*W-1:W];
         end
         2'b10: begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            return p[2*W-1:W];
         end
         default: begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            return p[W-1:0];
         end
      endcase
   endfunction

   // Issue one start at the next negedge, then wait (bounded) for done.
   // Operand inputs are scrambled while busy to show they are not re-sampled.
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] res, output int busy_cycles);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      wait_done(res, busy_cycles);
   endtask

   task automatic wait_done(output logic [W-1:0] res, output int busy_cycles);
      bit seen = 0;
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      busy_cycles = 0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin seen = 1; break; end
         if (busy) busy_cycles++;
         @(negedge clk);
      end
      if (!seen) check("timeout_done", W'(done), W'(1));
      res = result;
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 9))
         0:       return '0;
         1:       return W'(1);
         2:       return '1;
         3:       return {1'b1, {(W-1){1'b0}}};
         4:       return {1'b0, {(W-1){1'b1}}};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [W-1:0] res;
      logic [W-1:0] x, y;
      logic [1:0]   o;
      int           bc;
      int           d0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_busy", W'(busy), '0);
      check("reset_done", W'(done), '0);
      check("reset_result", result, '0);
      rst_n = 1'b1;

      // 1: MUL 7*6, latency and busy window
      d0 = done_total;
      do_op(2'b00, W'(7), W'(6), res, bc);
      check("mul_7x6", res, W'(42));
      check("mul_busy_cycles", W'(bc), W'(65));
      @(negedge clk);
      check("mul_done_pulses", W'(done_total - d0), W'(1));
      check("mul_result_held", result, W'(42));

      // 2: SMULH corner cases
      do_op(2'b01, '1, W'(1), res, bc);
      check("smulh_m1x1", res, '1);
      do_op(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, res, bc);
      check("smulh_min_sq", res, 64'h4000_0000_0000_0000);

      // 3: UMULH / MUL of all-ones
      do_op(2'b10, '1, '1, res, bc);
      check("umulh_ones", res, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(2'b00, '1, '1, res, bc);
      check("mul_ones", res, W'(1));

      // 4: start while busy is ignored; start in DONE chains back-to-back
      d0 = done_total;
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = W'(5); b = W'(5);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1; a = W'(3); b = W'(3);
      wait_done(res, bc);
      check("busy_start_ignored", res, W'(25));
      check("busy_single_done", W'(done_total - d0), W'(1));
      start = 1'b1; op = 2'b00; a = W'(3); b = W'(3);
      wait_done(res, bc);
      check("b2b_result", res, W'(9));
      check("b2b_busy_cycles", W'(bc), W'(65));

      // 5: asynchronous reset in the middle of a UMULH
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = '1; b = '1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", W'(busy), '0);
      check("arst_done", W'(done), '0);
      check("arst_result", result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      d0 = done_total;
      repeat (80) @(negedge clk);
      check("arst_no_done", W'(done_total - d0), '0);
      do_op(2'b00, W'(2), W'(3), res, bc);
      check("arst_then_mul", res, W'(6));

      // 6: randomized regression over all op codes, including reserved op=11
      for (int i = 0; i < 1000; i++) begin
         o = 2'($urandom);
         x = pick_operand();
         y = pick_operand();
         do_op(o, x, y, res, bc);
         check($sformatf("rand_%0d_op%0d", i, o), res, ref_mul(o, x, y));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
